picorv32_pcpi_divx: RTL

PICORV32_PCPI_DIVX -- requirements
Module: picorv32_pcpi_divx

---
 rtl/picorv32_pcpi_divx.sv | 137 +++++++++++++
 1 files changed

// File: rtl/picorv32_pcpi_divx.sv
// PCPI divider coprocessor for DIV/DIVU/REM/REMU using iterative restoring division.
// Resolves STEPS_AT_ONCE quotient bits per clock. FAST_SPECIAL short-cuts divide-by-zero and signed overflow.
`timescale 1ns/1ps
module picorv32_pcpi_divx #(
  parameter int STEPS_AT_ONCE = 1,
  parameter bit FAST_SPECIAL  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  localparam int         N      = 32 / STEPS_AT_ONCE;
  localparam logic [5:0] N_INIT = 6'(N);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [5:0]  count;
  logic        op_rem;
  logic        op_neg;
  logic [31:0] quo;      // dividend bits shift out of the top while quotient bits shift in
  logic [31:0] divisor;
  logic [31:0] rem_acc;

  logic        insn_div, op_rem_in, op_signed_in, rs1_neg, rs2_neg, neg_in, accept;
  logic        div_zero, signed_ovf, fast_hit;
  logic [31:0] rs1_mag, rs2_mag, fast_rd;
  logic        unused_insn_bits;

  assign insn_div     = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001) && pcpi_insn[14];
  assign op_rem_in    = pcpi_insn[13];
  assign op_signed_in = ~pcpi_insn[12];
  assign rs1_neg      = op_signed_in & pcpi_rs1[31];
  assign rs2_neg      = op_signed_in & pcpi_rs2[31];
  assign rs1_mag      = rs1_neg ? -pcpi_rs1 : pcpi_rs1;
  assign rs2_mag      = rs2_neg ? -pcpi_rs2 : pcpi_rs2;
  assign neg_in       = op_rem_in ? rs1_neg : ((rs1_neg != rs2_neg) && (pcpi_rs2 != 32'd0));
  assign accept       = (state == IDLE) && pcpi_valid && insn_div && !pcpi_ready;
  assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  assign div_zero   = (pcpi_rs2 == 32'd0);
  assign signed_ovf = op_signed_in && (pcpi_rs1 == 32'h8000_0000) && (pcpi_rs2 == 32'hFFFF_FFFF);
  assign fast_hit   = FAST_SPECIAL && (div_zero || signed_ovf);
  assign fast_rd    = div_zero ? (op_rem_in ? pcpi_rs1 : 32'hFFFF_FFFF)
                               : (op_rem_in ? 32'd0    : 32'h8000_0000);

  logic [32:0] step_rem;
  logic [31:0] step_quo;
  logic [31:0] res_mag;
  logic [31:0] result;

  // NOTE: blocking assignments here chain the unrolled steps within a single
  // evaluation; every output gets a default first so no latch is inferred.
  always_comb begin
    step_rem = {1'b0, rem_acc};
    step_quo = quo;
    for (int i = 0; i < STEPS_AT_ONCE; i++) begin
      step_rem = {step_rem[31:0], step_quo[31]};
      step_quo = {step_quo[30:0], 1'b0};
      if (step_rem >= {1'b0, divisor}) begin
        step_rem    = step_rem - {1'b0, divisor};
        step_quo[0] = 1'b1;
      end
    end
    res_mag = op_rem ? step_rem[31:0] : step_quo;
    result  = op_neg ? -res_mag : res_mag;
  end

  // NOTE: non-blocking assignments for all state; the datapath registers are
  // cleared too so a reset leaves no stale operands behind.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      count      <= 6'd0;
      pcpi_wr    <= 1'b0;
      pcpi_ready <= 1'b0;
      pcpi_wait  <= 1'b0;
      pcpi_rd    <= 32'd0;
      quo        <= 32'd0;
      divisor    <= 32'd0;
      rem_acc    <= 32'd0;
      op_rem     <= 1'b0;
      op_neg     <= 1'b0;
    end else begin
      pcpi_wr    <= 1'b0;
      pcpi_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (fast_hit) begin
              pcpi_wr    <= 1'b1;
              pcpi_ready <= 1'b1;
              pcpi_rd    <= fast_rd;
            end else begin
              state     <= RUN;
              pcpi_wait <= 1'b1;
              count     <= N_INIT;
              quo       <= rs1_mag;
              divisor   <= rs2_mag;
              rem_acc   <= 32'd0;
              op_rem    <= op_rem_in;
              op_neg    <= neg_in;
            end
          end
        end
        RUN: begin
          if (!pcpi_valid) begin
            // core withdrew the instruction: drop the work without a result
            state     <= IDLE;
            pcpi_wait <= 1'b0;
          end else begin
            quo     <= step_quo;
            rem_acc <= step_rem[31:0];
            count   <= count - 6'd1;
            if (count == 6'd1) begin
              state      <= IDLE;
              pcpi_wait  <= 1'b0;
              pcpi_wr    <= 1'b1;
              pcpi_ready <= 1'b1;
              pcpi_rd    <= result;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
